ct_f_spsram_256x52_ctrl: RTL and testbench
==========================================

# ct_f_spsram_256x52_ctrl

Access controller for one 256x52 single-port SRAM macro (active-low CEN/GWEN/WEN, registered read data). After reset, and on demand, it sweeps all 256 entries to zero. It then shares the macro between two requesters (p0, p1) with a round-robin arbiter, one access per cycle. It sits between the owning pipeline logic and the SRAM instance. All SRAM-side outputs are registered.

## Interface
- ADDR_WIDTH, 8, SRAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 52, SRAM word width; must be even, split into two halves of DATA_WIDTH/2.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- pN_req  in  1  access request, N=0,1; held with its fields until pN_gnt.
- pN_wr  in  1  1 = write, 0 = read.
- pN_addr  in  ADDR_WIDTH  word address.
- pN_wdata  in  DATA_WIDTH  write data.
- pN_wbe  in  2  half enables; bit0 = [25:0], bit1 = [51:26].
- pN_gnt  out  1  combinational accept; request consumed this cycle.
- pN_rvalid  out  1  read data for pN valid on rdata this cycle.
- rdata  out  DATA_WIDTH  equals sram_q; shared by both ports.
- clr_req  in  1  single-cycle pulse; restarts the zero sweep.
- init_done  out  1  sweep complete; arbitration enabled.
- sram_a  out  ADDR_WIDTH  to macro A.
- sram_cen  out  1  to macro CEN, active-low.
- sram_gwen  out  1  to macro GWEN, active-low.
- sram_wen  out  DATA_WIDTH  to macro WEN, active-low per bit.
- sram_d  out  DATA_WIDTH  to macro D.
- sram_q  in  DATA_WIDTH  from macro Q.

## Operation
- FSM states: INIT, RUN.
  - RST forces INIT, sweep counter = 0, rr pointer = 1 (p0 wins first contention).
- INIT:
  - Each cycle, load registers with a write: cen=0, gwen=0, wen=all 0, d=0, a=counter. Counter increments.
  - When the load with counter=255 occurs, move to RUN and set init_done=1 at the same edge.
  - pN_gnt is forced to 0. clr_req is ignored.
- RUN:
  - clr_req=1 has top priority. No grant that cycle. Next edge: state=INIT, counter=0, init_done=0, SRAM regs idle (cen=1).
  - Otherwise the arbiter runs:
    - Single requester: it is granted.
    - Both requesting: grant the port not indicated by the rr pointer. The pointer updates to the granted port on each grant.
  - Granted write loads: cen=0, gwen=0, a=addr, d=wdata, wen[25:0]={26{~wbe[0]}}, wen[51:26]={26{~wbe[1]}}.
  - A write with wbe=00 is still granted and issued; memory contents do not change.
  - Granted read loads: cen=0, gwen=1, wen=all 1, a=addr. d holds its previous value.
  - No grant: cen=1, gwen=1, wen=all 1. a and d hold.
- rvalid pipeline: 2-stage shift of {granted read, port id}. pN_rvalid is a 1-cycle pulse.
- Accesses execute in grant order. A read granted the cycle after a write to the same address returns the new data.

## Timing
- Reset values: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0, init_done=0, pN_rvalid=0, pN_gnt=0.
- Edge 0 is the first rising edge with RST low.
  - Sweep writes are loaded at edges 0..255.
  - init_done=1 after edge 255.
  - The first grant is possible in the cycle after edge 255.
- Read latency:
  - gnt in cycle t.
  - SRAM access in cycle t+1.
  - pN_rvalid=1 and rdata valid in cycle t+2.
- Throughput: one access per cycle. Back-to-back grants are allowed.
- Reset mid-operation:
  - Asynchronous; all state and outputs return to reset values immediately.
  - In-flight rvalid pulses are dropped.
  - The sweep restarts from address 0.
- clr_req while a read is in flight: that read's rvalid/rdata still completes at t+2, because the macro output is registered.

## Test plan
- Reset release:
  - Exactly 256 sweep writes, addresses 0..255, d=0, wen=0.
  - init_done rises after edge 255.
  - Any requests raised during the sweep get no gnt until then.
- p0 write addr 0x12 data 0xA_BCDE_F012_3456 wbe=11, then p0 read 0x12:
  - p0_gnt on both requests.
  - p0_rvalid 2 cycles after the read grant, with rdata = 0xA_BCDE_F012_3456.
  - p1_rvalid stays 0 throughout.
- p0 and p1 both request reads continuously for 6 cycles after init:
  - Grants alternate p0,p1,p0,p1,p0,p1.
  - rvalid follows the same order 2 cycles later.
- Write 0xF_FFFF_FFFF_FFFF to 0x40 (wbe=11), then write 0 with wbe=01, then read 0x40:
  - rdata = 0xF_FFFF_FC00_0000 (bits [51:26] all 1, [25:0] all 0).
  - A wbe=00 write leaves the word unchanged.
- Mid-traffic and mid-sweep events:
  - clr_req pulse with p1 requesting: no gnt that cycle; init_done falls; a full 256-write sweep runs; a read of 0x40 afterwards returns 0.
  - RST asserted mid-sweep at counter=100: outputs return to reset values at once; after release, the sweep restarts at address 0.

Source files
------------

// File: rtl/ct_f_spsram_256x52_ctrl.sv
// Access controller for a single-port SRAM macro with active-low CEN/GWEN/WEN.
// After reset, or on a clear pulse, it writes zero to every entry. It then
// shares the macro between two requesters using a round-robin arbiter.
// Every SRAM-side output comes straight from a flop. The read data path is
// the macro's own registered Q.
module ct_f_spsram_256x52_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 52
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  p0_req,
    input  logic                  p0_wr,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [1:0]            p0_wbe,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    input  logic                  p1_req,
    input  logic                  p1_wr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [1:0]            p1_wbe,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  clr_req,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int HALF_W = DATA_WIDTH / 2;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rr_q, rr_d;          // last granted port id
    logic                  init_done_q, init_done_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic                  cen_q, cen_d;
    logic                  gwen_q, gwen_d;
    logic [DATA_WIDTH-1:0] wen_q, wen_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_id_q, s1_id_d;
    logic                  s2_vld_q, s2_vld_d;
    logic                  s2_id_q, s2_id_d;

    logic                  arb_en;
    logic                  gnt0;
    logic                  gnt1;
    logic                  gnt_any;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]            sel_wbe;
    logic [DATA_WIDTH-1:0] sel_wen;

    // Arbitration: clr_req blocks all grants. Under contention, the port
    // that was not granted last wins.
    always_comb begin
        arb_en    = (state_q == ST_RUN) && !clr_req;
        gnt0      = arb_en && p0_req && (!p1_req || rr_q);
        gnt1      = arb_en && p1_req && (!p0_req || !rr_q);
        gnt_any   = gnt0 || gnt1;
        sel_wr    = gnt1 ? p1_wr    : p0_wr;
        sel_addr  = gnt1 ? p1_addr  : p0_addr;
        sel_wdata = gnt1 ? p1_wdata : p0_wdata;
        sel_wbe   = gnt1 ? p1_wbe   : p0_wbe;
    end

    // Each half-word enable expands to an active-low mask over its half.
    for (genvar gi = 0; gi < 2; gi++) begin : g_wen_half
        assign sel_wen[gi*HALF_W +: HALF_W] = {HALF_W{~sel_wbe[gi]}};
    end

    // Next-state logic for the sweep FSM, the SRAM command registers and the
    // read-return pipeline.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        init_done_d = init_done_q;
        a_d         = a_q;
        d_d         = d_q;
        cen_d       = 1'b1;
        gwen_d      = 1'b1;
        wen_d       = '1;
        s1_vld_d    = 1'b0;
        s1_id_d     = 1'b0;
        s2_vld_d    = s1_vld_q;
        s2_id_d     = s1_id_q;

        case (state_q)
            ST_INIT: begin
                cen_d  = 1'b0;
                gwen_d = 1'b0;
                wen_d  = '0;
                d_d    = '0;
                a_d    = cnt_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d     = ST_INIT;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end else if (gnt_any) begin
                    rr_d  = gnt1;
                    cen_d = 1'b0;
                    a_d   = sel_addr;
                    if (sel_wr) begin
                        gwen_d = 1'b0;
                        wen_d  = sel_wen;
                        d_d    = sel_wdata;
                    end else begin
                        s1_vld_d = 1'b1;
                        s1_id_d  = gnt1;
                    end
                end
            end
        endcase
    end

    // State registers. Reset is asynchronous, so outputs return to idle at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rr_q        <= 1'b1;
            init_done_q <= 1'b0;
            a_q         <= '0;
            cen_q       <= 1'b1;
            gwen_q      <= 1'b1;
            wen_q       <= '1;
            d_q         <= '0;
            s1_vld_q    <= 1'b0;
            s1_id_q     <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_id_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            init_done_q <= init_done_d;
            a_q         <= a_d;
            cen_q       <= cen_d;
            gwen_q      <= gwen_d;
            wen_q       <= wen_d;
            d_q         <= d_d;
            s1_vld_q    <= s1_vld_d;
            s1_id_q     <= s1_id_d;
            s2_vld_q    <= s2_vld_d;
            s2_id_q     <= s2_id_d;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = s2_vld_q && !s2_id_q;
    assign p1_rvalid = s2_vld_q && s2_id_q;
    assign rdata     = sram_q;
    assign init_done = init_done_q;
    assign sram_a    = a_q;
    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_d    = d_q;

endmodule

// File: tb/tb_ct_f_spsram_256x52_ctrl.sv
// Testbench for ct_f_spsram_256x52_ctrl. It contains a macro model and a
// reference memory/arbiter model. Directed tests are followed by random traffic.
module tb_ct_f_spsram_256x52_ctrl;

    localparam int AW = 8;
    localparam int DW = 52;

    logic          CLK = 1'b0;
    logic          RST;
    logic          p0_req, p0_wr, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic [1:0]    p0_wbe;
    logic          p1_req, p1_wr, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [1:0]    p1_wbe;
    logic [DW-1:0] rdata;
    logic          clr_req, init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    always #5 CLK = ~CLK;

    ct_f_spsram_256x52_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wbe(p0_wbe), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wbe(p1_wbe), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .clr_req(clr_req), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Macro model: bit-masked write, registered read.
    logic [DW-1:0] mem [256];
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          exq[$];
    logic [DW-1:0] ref_mem [256];
    int            n_m;          // sweep edges completed; >= 256 means arbitration enabled
    bit            sweep_edge;   // last edge loaded a sweep write
    bit            acc_exp;      // last edge loaded a granted access
    bit            g_any;
    int            g_port;
    int            last_m;
    int            cyc = 0;

    bit            r_req [2];
    bit            r_wr  [2];
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wd  [2];
    logic [1:0]    r_be  [2];
    bit            r_clr;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            n_m <= 0; sweep_edge <= 1'b0; acc_exp <= 1'b0;
        end else begin
            sweep_edge <= (n_m < 256);
            acc_exp    <= g_any;
            if (n_m < 256)    n_m <= n_m + 1;
            else if (clr_req) n_m <= 0;
        end
    end

    // Output monitor on the falling edge.
    always @(negedge CLK) begin
        bit e0, e1;
        e0 = 1'b0; e1 = 1'b0;
        check_val("init_done", init_done, n_m >= 256);
        if (sweep_edge) begin
            check_val("sweep_a", sram_a, n_m - 1);
            check_val("sweep_ctl", {sram_cen, sram_gwen, |sram_wen, |sram_d}, 4'b0000);
        end else begin
            check_val("cen_idle", sram_cen, !acc_exp);
        end
        if (exq.size() > 0 && exq[0].due == cyc) begin
            if (exq[0].port) e1 = 1'b1; else e0 = 1'b1;
            check_val("rdata", rdata, exq[0].data);
            void'(exq.pop_front());
        end
        check_val("rvalid", {p1_rvalid, p0_rvalid}, {e1, e0});
    end

    task automatic clear_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    // One cycle, entered and left 1 time unit after a rising edge.
    task automatic run_cycle();
        int g;
        p0_req = r_req[0]; p0_wr = r_wr[0]; p0_addr = r_addr[0]; p0_wdata = r_wd[0]; p0_wbe = r_be[0];
        p1_req = r_req[1]; p1_wr = r_wr[1]; p1_addr = r_addr[1]; p1_wdata = r_wd[1]; p1_wbe = r_be[1];
        clr_req = r_clr;
        #1;
        g = -1;
        if (n_m >= 256 && !r_clr) begin
            if (r_req[0] && r_req[1]) g = (last_m == 0) ? 1 : 0;
            else if (r_req[0])        g = 0;
            else if (r_req[1])        g = 1;
        end
        check_val("gnt", {p1_gnt, p0_gnt}, (g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00);
        g_any  = (g >= 0);
        g_port = g;
        if (g >= 0) begin
            last_m = g;
            if (r_wr[g]) begin
                if (r_be[g][0]) ref_mem[r_addr[g]][25:0]  = r_wd[g][25:0];
                if (r_be[g][1]) ref_mem[r_addr[g]][51:26] = r_wd[g][51:26];
            end else begin
                exq.push_back('{due: cyc + 2, port: (g == 1), data: ref_mem[r_addr[g]]});
            end
            r_req[g] = 1'b0;
        end
        if (r_clr && n_m >= 256) clear_ref();
        r_clr = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic arm(input int p, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [1:0] be);
        if (!r_req[p]) begin
            r_req[p] = 1'b1; r_wr[p] = wr; r_addr[p] = a; r_wd[p] = wd; r_be[p] = be;
        end
    endtask

    task automatic issue(input int p, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [1:0] be);
        arm(p, wr, a, wd, be);
        for (int i = 0; i < 600 && r_req[p]; i++) run_cycle();
        check_val("issue_timeout", r_req[p], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        exq.delete();
        last_m = 1;
        g_any  = 1'b0;
        clear_ref();
        #1;
        check_val("rst_out", {sram_cen, sram_gwen, &sram_wen, |sram_a, |sram_d, init_done,
                              p0_rvalid, p1_rvalid, p0_gnt, p1_gnt}, 10'b1110000000);
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        int k;
        RST = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = DW'({$urandom(), $urandom()});
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; r_wr[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0; r_be[p] = '0;
        end
        r_clr = 1'b0; g_any = 1'b0; last_m = 1;
        p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0; p0_wbe = '0;
        p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0; p1_wbe = '0;
        clr_req = 0;
        @(posedge CLK); #1;
        do_reset();

        // Sweep with p1 requesting throughout: it is granted in the cycle after edge 255.
        arm(1, 1'b0, 8'h05, '0, 2'b00);
        k = 0;
        while (r_req[1] && k < 400) begin run_cycle(); k++; end
        check_val("first_gnt_cycle", k, 257);

        // Continuous contention: grants alternate starting with p0.
        for (int i = 0; i < 6; i++) begin
            arm(0, 1'b0, AW'(i), '0, 2'b00);
            arm(1, 1'b0, AW'(i + 8), '0, 2'b00);
            run_cycle();
            check_val("alt_order", g_port, i % 2);
        end
        idle(4);

        // Write then read 0x12, back to back.
        issue(0, 1'b1, 8'h12, 52'hA_BCDE_F012_3456, 2'b11);
        issue(0, 1'b0, 8'h12, '0, 2'b00);
        run_cycle();
        check_val("rd12", {p1_rvalid, p0_rvalid, rdata}, {2'b01, 52'hA_BCDE_F012_3456});
        idle(2);

        // Half-word write enables.
        issue(0, 1'b1, 8'h40, 52'hF_FFFF_FFFF_FFFF, 2'b11);
        issue(0, 1'b1, 8'h40, 52'h0, 2'b01);
        issue(0, 1'b0, 8'h40, '0, 2'b00);
        run_cycle();
        check_val("rd40_half", {p0_rvalid, rdata}, {1'b1, 52'hF_FFFF_FC00_0000});
        issue(1, 1'b1, 8'h40, 52'h1_2345_6789_ABCD, 2'b00);
        issue(1, 1'b0, 8'h40, '0, 2'b00);
        run_cycle();
        check_val("rd40_be00", {p1_rvalid, rdata}, {1'b1, 52'hF_FFFF_FC00_0000});
        idle(2);

        // Read in flight when clr_req arrives, then clear with p1 requesting.
        issue(0, 1'b0, 8'h40, '0, 2'b00);
        arm(1, 1'b0, 8'h40, '0, 2'b00);
        r_clr = 1'b1;
        run_cycle();
        check_val("clr_init_done", init_done, 1'b0);
        k = 0;
        while (r_req[1] && k < 400) begin run_cycle(); k++; end
        check_val("clr_gnt_cycle", k, 257);
        run_cycle();
        check_val("rd40_clr", {p1_rvalid, rdata}, {1'b1, 52'h0});
        idle(2);

        // Reset in the middle of a sweep.
        r_clr = 1'b1;
        run_cycle();
        while (n_m < 100) run_cycle();
        check_val("pre_rst_a", sram_a, 99);
        arm(0, 1'b0, 8'h07, '0, 2'b00);
        do_reset();
        run_cycle();
        check_val("restart_a", {sram_cen, sram_a}, 9'h000);
        k = 0;
        while (r_req[0] && k < 400) begin run_cycle(); k++; end
        check_val("rst_gnt_cycle", k, 256);

        // Random traffic on a small address window to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p] && $urandom_range(0, 3) != 0)
                    arm(p, 1'($urandom_range(0, 1)), AW'($urandom_range(8'h80, 8'h8F)),
                        DW'({$urandom(), $urandom()}), 2'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 499) == 0) r_clr = 1'b1;
            run_cycle();
        end
        k = 0;
        while ((r_req[0] || r_req[1]) && k < 600) begin run_cycle(); k++; end
        check_val("drain", {r_req[1], r_req[0]}, 2'b00);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
